fetch_unit: RTL and testbench

//  Parametrised instruction-fetch stage for the pipelined core that replaces the single-cycle datapath.

---
 rtl/fetch_unit.sv | 113 +++++++++++
 tb/tb_fetch_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order memory requests and
// buffers PC-tagged instructions in a small FIFO that decode drains.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter int              ADDR_W   = 13,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       redirect_i,
  input  logic [XLEN-1:0]            redirect_pc_i,
  output logic                       imem_req_valid_o,
  input  logic                       imem_req_ready_i,
  output logic [ADDR_W-1:0]          imem_addr_o,
  input  logic                       imem_rsp_valid_i,
  input  logic [ILEN-1:0]            imem_rsp_data_i,
  output logic                       instr_valid_o,
  input  logic                       instr_ready_i,
  output logic [ILEN-1:0]            instr_o,
  output logic [XLEN-1:0]            instr_pc_o,
  output logic [XLEN-1:0]            instr_pc_four_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [ILEN-1:0] NOP = ILEN'(32'h0000_0013);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; once valid is raised its payload holds until that transfer.
  // The response channel has no ready: every response is consumed on arrival.

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_outst;
  logic [CW-1:0]   r_drop;
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [ILEN-1:0] r_instr_mem [DEPTH];
  logic [XLEN-1:0] r_pc_mem    [DEPTH];

  logic            w_credit;
  logic            w_req_fire;
  logic            w_empty;
  logic            w_deq;
  logic            w_drop_now;
  logic            w_enq;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_instr_pc;

  // Dropped slots still hold credit until their response has returned.
  assign w_credit   = ({1'b0, r_count} + {1'b0, r_outst}) < (CW+1)'(DEPTH);
  assign imem_req_valid_o = !rst_i && !redirect_i && w_credit;
  assign w_req_fire = imem_req_valid_o && imem_req_ready_i;
  assign w_empty    = (r_count == '0);
  assign w_deq      = !w_empty && instr_ready_i && !redirect_i;
  assign w_drop_now = (r_drop != '0);
  assign w_enq      = imem_rsp_valid_i && !redirect_i && !w_drop_now;
  assign w_target   = {redirect_pc_i[XLEN-1:2], 2'b00};

  assign imem_addr_o = r_fetch_pc[ADDR_W-1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_count    <= '0;
      r_outst    <= '0;
      r_drop     <= '0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      r_outst <= r_outst + CW'(w_req_fire) - CW'(imem_rsp_valid_i);
      if (redirect_i) begin
        // Everything in flight, including a response arriving right now, is stale.
        r_fetch_pc <= w_target;
        r_rsp_pc   <= w_target;
        r_count    <= '0;
        r_head     <= '0;
        r_tail     <= '0;
        r_drop     <= r_outst - CW'(imem_rsp_valid_i);
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + XLEN'(4);
        if (imem_rsp_valid_i && w_drop_now) r_drop <= r_drop - CW'(1);
        if (w_enq) begin
          r_rsp_pc <= r_rsp_pc + XLEN'(4);
          r_tail   <= r_tail + PW'(1);
        end
        if (w_deq) r_head <= r_head + PW'(1);
        r_count <= r_count + CW'(w_enq) - CW'(w_deq);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_instr_mem[r_tail] <= imem_rsp_data_i;
      r_pc_mem[r_tail]    <= r_rsp_pc;
    end
  end

  // When empty, the PC shown is the next one expected back (RESET_PC after reset).
  assign w_instr_pc      = w_empty ? r_rsp_pc : r_pc_mem[r_head];
  assign instr_valid_o   = !w_empty;
  assign instr_o         = w_empty ? NOP : r_instr_mem[r_head];
  assign instr_pc_o      = w_instr_pc;
  assign instr_pc_four_o = w_instr_pc + XLEN'(4);
  assign count_o         = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model returning addr^KEY, directed redirect and
// stall scenarios, expected-PC queue checked by an independent monitor.
module tb_fetch_unit;

  localparam logic [31:0] KEY = 32'h1357_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        req_valid;
  logic        req_ready = 1'b1;
  logic [12:0] addr;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_four;
  logic [2:0]  count;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  logic [12:0] mq_addr[$];
  int          mq_due[$];
  int          cyc = 0;
  int          lat = 1;
  int          acc_cnt = 0;
  logic        rand_ready = 1'b0;
  logic        prev_stall = 1'b0;
  logic [12:0] prev_addr = '0;
  logic [31:0] e;

  fetch_unit dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .redirect_i       (redirect),
    .redirect_pc_i    (redirect_pc),
    .imem_req_valid_o (req_valid),
    .imem_req_ready_i (req_ready),
    .imem_addr_o      (addr),
    .imem_rsp_valid_i (rsp_valid),
    .imem_rsp_data_i  (rsp_data),
    .instr_valid_o    (instr_valid),
    .instr_ready_i    (instr_ready),
    .instr_o          (instr),
    .instr_pc_o       (instr_pc),
    .instr_pc_four_o  (instr_pc_four),
    .count_o          (count)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory model: in-order responses, fixed latency, reset by rst
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      mq_addr.delete();
      mq_due.delete();
    end else if (rsp_valid) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    #1;
    req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (!rst && mq_due.size() > 0 && mq_due[0] <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = {19'b0, mq_addr[0]} ^ KEY;
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = '0;
    end
  end

  // monitor / scoreboard
  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (req_valid && req_ready) begin
        acc_cnt++;
        mq_addr.push_back(addr);
        mq_due.push_back(cyc + lat);
      end
      if (prev_stall && req_valid) check("addr_stable", {19'b0, addr}, {19'b0, prev_addr});
      prev_stall = req_valid && !req_ready;
      prev_addr  = addr;
      if (instr_valid && instr_ready && !redirect) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_instr: got pc %h expected none", instr_pc);
        end else begin
          e = exp_q.pop_front();
          check("instr_pc", instr_pc, e);
          check("instr", instr, e ^ KEY);
          check("instr_pc_four", instr_pc_four, e + 32'd4);
        end
      end
    end
  end

  // driver tasks (all called just after a rising edge)
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d left expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    acc_cnt  = 0;
  endtask

  initial begin
    // reset state and streaming from RESET_PC
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", {31'b0, req_valid}, 32'd0);
    check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instr, NOP);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_instr_pc_four", instr_pc_four, 32'h4);
    check("rst_count", {29'b0, count}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    instr_ready = 1'b1;
    push_seq(32'h0, 8);
    @(negedge clk);
    check("c0_req_valid", {31'b0, req_valid}, 32'd1);
    check("c0_addr", {19'b0, addr}, 32'h0);
    check("c0_instr_valid", {31'b0, instr_valid}, 32'd0);
    @(negedge clk);
    check("c1_instr_valid", {31'b0, instr_valid}, 32'd0);
    @(negedge clk);
    check("c2_instr_valid", {31'b0, instr_valid}, 32'd1);
    @(posedge clk);
    #1;
    drain(30);
    instr_ready = 1'b0;

    // full FIFO: exactly DEPTH accepts, then credit stops requests
    do_redirect(32'h200);
    idle(10);
    check("full_accepts", 32'(acc_cnt), 32'd4);
    check("full_req_valid", {31'b0, req_valid}, 32'd0);
    check("full_count", {29'b0, count}, 32'd4);
    check("full_head_pc", instr_pc, 32'h200);
    push_seq(32'h200, 8);
    instr_ready = 1'b1;
    drain(40);
    instr_ready = 1'b0;
    idle(8);

    // redirect with two requests outstanding on a 3-cycle memory
    lat = 3;
    instr_ready = 1'b1;
    do_redirect(32'h040);
    for (int i = 0; i < 20 && acc_cnt < 2; i++) idle(1);
    check("t3_outstanding", 32'(acc_cnt), 32'd2);
    do_redirect(32'h300);
    push_seq(32'h300, 8);
    drain(80);
    instr_ready = 1'b0;
    idle(12);
    lat = 1;

    // redirect coinciding with a response and a dequeue
    instr_ready = 1'b1;
    do_redirect(32'h400);
    push_seq(32'h400, 4);
    drain(20);
    redirect    = 1'b1;
    redirect_pc = 32'h500;
    @(negedge clk);
    check("t4_deq_same_cycle", {31'b0, instr_valid}, 32'd1);
    check("t4_rsp_same_cycle", {31'b0, rsp_valid}, 32'd1);
    @(posedge clk);
    #1;
    redirect = 1'b0;
    push_seq(32'h500, 4);
    @(negedge clk);
    check("t4_count_flushed", {29'b0, count}, 32'd0);
    check("t4_valid_flushed", {31'b0, instr_valid}, 32'd0);
    check("t4_nop_empty", instr, NOP);
    @(posedge clk);
    #1;
    drain(20);
    instr_ready = 1'b0;
    idle(8);

    // request-side back-pressure toggling
    rand_ready  = 1'b1;
    instr_ready = 1'b1;
    do_redirect(32'h600);
    push_seq(32'h600, 16);
    drain(300);
    rand_ready  = 1'b0;
    instr_ready = 1'b0;
    idle(8);

    // unaligned target, then asynchronous reset mid-stream
    instr_ready = 1'b1;
    do_redirect(32'h702);
    push_seq(32'h700, 4);
    drain(20);
    instr_ready = 1'b0;
    idle(8);
    check("t6_full_before_rst", {29'b0, count}, 32'd4);
    rst = 1'b1;
    #1;
    check("arst_req_valid", {31'b0, req_valid}, 32'd0);
    check("arst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check("arst_instr", instr, NOP);
    check("arst_instr_pc", instr_pc, 32'h0);
    check("arst_instr_pc_four", instr_pc_four, 32'h4);
    check("arst_count", {29'b0, count}, 32'd0);
    idle(2);
    rst = 1'b0;
    instr_ready = 1'b1;
    push_seq(32'h0, 4);
    @(negedge clk);
    check("restart_req_valid", {31'b0, req_valid}, 32'd1);
    check("restart_addr", {19'b0, addr}, 32'h0);
    @(posedge clk);
    #1;
    drain(20);
    instr_ready = 1'b0;
    idle(4);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
